keypad_scanner: RTL

//  Scans a 4x4 matrix keypad (Pmod KYPD) and delivers debounced key-press codes to the processor.

---
 rtl/keypad_scanner_pkg.sv | 30 +++
 rtl/keypad_scanner_if.sv | 28 ++
 rtl/keypad_scanner_debounce.sv | 63 ++++++
 rtl/keypad_scanner.sv | 125 ++++++++++++
 4 files changed

// File: rtl/keypad_scanner_pkg.sv
// Shared types and constants for the 4x4 matrix keypad scanner.
// Internal key state is {none_flag, code}; KEY_NONE has the flag set.
package keypad_scanner_pkg;

    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 4;

    typedef logic [3:0] key_code_t;
    typedef logic [4:0] key_state_t;

    localparam key_state_t KEY_NONE = 5'b1_0000;

    typedef enum logic {
        S_DRIVE  = 1'b0,
        S_SAMPLE = 1'b1
    } scan_state_e;

    // KEYMAP[row][col], ascending indices so row 0 / col 0 come first.
    localparam logic [0:3][0:3][3:0] KEYMAP = '{
        '{4'h1, 4'h2, 4'h3, 4'hA},
        '{4'h4, 4'h5, 4'h6, 4'hB},
        '{4'h7, 4'h8, 4'h9, 4'hC},
        '{4'h0, 4'hF, 4'hE, 4'hD}
    };

    function automatic key_state_t key_of(input logic [1:0] row, input logic [1:0] col);
        return {1'b0, KEYMAP[row][col]};
    endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// CPU-side key event port. key_valid/key_ack form a hold-until-acked handshake:
// key_valid stays high with a stable key_code until a cycle where key_ack=1 and key_valid=1.
interface keypad_scanner_if;
    import keypad_scanner_pkg::*;

    key_code_t key_code;
    logic      key_valid;
    logic      key_ack;
    logic      key_down;
    logic      overrun;

    modport master (
        output key_code,
        output key_valid,
        output key_down,
        output overrun,
        input  key_ack
    );

    modport slave (
        input  key_code,
        input  key_valid,
        input  key_down,
        input  overrun,
        output key_ack
    );

endinterface

// File: rtl/keypad_scanner_debounce.sv
// Accepts a new key state only after DEBOUNCE_SCANS identical full-scan results;
// emits a one-cycle press pulse on none->K and K1->K2 transitions.
module keypad_scanner_debounce
    import keypad_scanner_pkg::*;
#(
    parameter int DEBOUNCE_SCANS = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scan_valid_i,
    input  key_state_t scan_result_i,
    output key_state_t state_o,
    output logic       press_o,
    output logic       key_down_o
);

    localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_SCANS);

    key_state_t    prev_q, prev_d;
    key_state_t    state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic          press_q, press_d;

    always_comb begin
        prev_d  = prev_q;
        count_d = count_q;
        state_d = state_q;
        press_d = 1'b0;
        if (scan_valid_i) begin
            prev_d = scan_result_i;
            if (scan_result_i == prev_q) begin
                count_d = (count_q == CMAX) ? CMAX : count_q + 1'b1;
            end else begin
                count_d = CW'(1);
            end
            // Release (K->none) updates the state but is not a press.
            if (count_d == CMAX && scan_result_i != state_q) begin
                state_d = scan_result_i;
                press_d = !scan_result_i[4];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q  <= KEY_NONE;
            count_q <= '0;
            state_q <= KEY_NONE;
            press_q <= 1'b0;
        end else begin
            prev_q  <= prev_d;
            count_q <= count_d;
            state_q <= state_d;
            press_q <= press_d;
        end
    end

    assign state_o    = state_q;
    assign press_o    = press_q;
    assign key_down_o = !state_q[4];

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: column strobe FSM, row synchronizer, debounce and a
// single-entry key event register read by the CPU.
module keypad_scanner
    import keypad_scanner_pkg::*;
#(
    parameter int SETTLE_CYCLES  = 1000,
    parameter int DEBOUNCE_SCANS = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        rows_i,
    output logic [3:0]        cols_o,
    output scan_state_e       state_o,
    keypad_scanner_if.master  kif
);

    localparam int SW = $clog2(SETTLE_CYCLES + 1);

    logic [3:0]    rows_meta_q, rows_sync_q;
    scan_state_e   state_q;
    logic [1:0]    col_q;
    logic [3:0]    cols_q;
    logic [SW-1:0] settle_q;
    key_state_t    acc_q;

    key_state_t    col_hit, scan_res;
    logic          scan_vld;

    key_state_t    deb_state;
    logic          press, key_down;

    key_code_t     code_q;
    logic          valid_q, overrun_q;
    logic          ack;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rows_meta_q <= 4'b1111;
            rows_sync_q <= 4'b1111;
        end else begin
            rows_meta_q <= rows_i;
            rows_sync_q <= rows_meta_q;
        end
    end

    // Lowest row in the current column wins; earlier columns win over later ones.
    always_comb begin
        col_hit = KEY_NONE;
        for (int r = NUM_ROWS - 1; r >= 0; r--) begin
            if (!rows_sync_q[r]) col_hit = key_of(2'(r), col_q);
        end
        scan_res = (col_q != 2'd0 && !acc_q[4]) ? acc_q : col_hit;
        scan_vld = (state_q == S_SAMPLE) && (col_q == 2'(NUM_COLS - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_DRIVE;
            col_q    <= 2'd0;
            cols_q   <= 4'b1110;
            settle_q <= '0;
            acc_q    <= KEY_NONE;
        end else begin
            case (state_q)
                S_DRIVE: begin
                    if (settle_q == SW'(SETTLE_CYCLES - 1)) begin
                        state_q  <= S_SAMPLE;
                        settle_q <= '0;
                    end else begin
                        settle_q <= settle_q + 1'b1;
                    end
                end
                S_SAMPLE: begin
                    acc_q   <= scan_res;
                    col_q   <= col_q + 2'd1;
                    cols_q  <= {cols_q[2:0], cols_q[3]};
                    state_q <= S_DRIVE;
                end
                default: state_q <= S_DRIVE;
            endcase
        end
    end

    keypad_scanner_debounce #(
        .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
    ) u_debounce (
        .clk          (clk),
        .rst_n        (rst_n),
        .scan_valid_i (scan_vld),
        .scan_result_i(scan_res),
        .state_o      (deb_state),
        .press_o      (press),
        .key_down_o   (key_down)
    );

    assign ack = kif.key_ack && valid_q;

    // A press coincident with an ack replaces the consumed code without dropping valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            code_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else if (press) begin
            if (!valid_q || ack) begin
                code_q  <= deb_state[3:0];
                valid_q <= 1'b1;
                if (ack) overrun_q <= 1'b0;
            end else begin
                overrun_q <= 1'b1;
            end
        end else if (ack) begin
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end
    end

    assign cols_o        = cols_q;
    assign state_o       = state_q;
    assign kif.key_code  = code_q;
    assign kif.key_valid = valid_q;
    assign kif.overrun   = overrun_q;
    assign kif.key_down  = key_down;

endmodule
